// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Round-robin arbiter that funnels NUM_REQ simple request ports onto one
//   APB requester interface. Each grant runs one full SETUP/ACCESS transfer.
//   A transfer that waits TIMEOUT cycles with pready low is aborted and
//   reported as an error.
//
// Ports
//   pclk, presetn        clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester request / one-hot acceptance pulse
//   req_addr/write/wdata/strb/prot  packed per-requester request fields
//   rsp_valid/id/rdata/slverr       one-cycle completion report
//   paddr..pstrb         APB request outputs (registered)
//   pready/prdata/pslverr           APB completer response inputs
module apb_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                              pclk,
    input  logic                              presetn,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_strb,
    input  logic [NUM_REQ*3-1:0]              req_prot,
    output logic                              rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_slverr,
    output logic [ADDR_WIDTH-1:0]             paddr,
    output logic [2:0]                        pprot,
    output logic                              pnse,
    output logic                              psel,
    output logic                              penable,
    output logic                              pwrite,
    output logic [DATA_WIDTH-1:0]             pwdata,
    output logic [DATA_WIDTH/8-1:0]           pstrb,
    input  logic                              pready,
    input  logic [DATA_WIDTH-1:0]             prdata,
    input  logic                              pslverr
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;     // first index searched at the next grant
    logic [ID_W-1:0]    cur_id;     // requester owning the current transfer
    logic [CNT_W-1:0]   wait_cnt;   // ACCESS cycles seen with pready low

    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    next_ptr;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_write;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_W-1:0]     sel_strb;
    logic [2:0]            sel_prot;

    // Round-robin search: walk the indices starting at rr_ptr, wrapping at
    // NUM_REQ-1, and take the first one that is requesting.
    always_comb begin
        // NOTE: every variable a combinational block writes gets a default
        // before any conditional assignment; otherwise a latch is inferred.
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
            cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Fields of the winning requester, selected with constant slices.
    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_prot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_write = req_write[i];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = req_strb[i*STRB_W +: STRB_W];
                sel_prot  = req_prot[i*3 +: 3];
            end
        end
    end

    // Acceptance is combinational so a requester sees it in the grant cycle;
    // gating with presetn keeps it low while reset is asserted.
    assign req_ready = (presetn && state == IDLE && grant_any)
                       ? (NUM_REQ'(1) << grant_id) : '0;

    assign pnse = 1'b0;

    // The captured request fields are the APB output registers themselves;
    // they are zeroed whenever the bus is idle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            wait_cnt   <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            pstrb      <= '0;
            pprot      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state  <= SETUP;
                        psel   <= 1'b1;
                        paddr  <= sel_addr;
                        pwrite <= sel_write;
                        pwdata <= sel_write ? sel_wdata : '0;
                        pstrb  <= sel_write ? sel_strb : '0;
                        pprot  <= sel_prot;
                        cur_id <= grant_id;
                        rr_ptr <= next_ptr;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    // The TIMEOUT-th consecutive cycle with pready low ends
                    // the transfer as an error.
                    if (pready || wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state      <= IDLE;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        paddr      <= '0;
                        pwrite     <= 1'b0;
                        pwdata     <= '0;
                        pstrb      <= '0;
                        pprot      <= '0;
                        wait_cnt   <= '0;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= cur_id;
                        rsp_slverr <= pready ? pslverr : 1'b1;
                        rsp_rdata  <= (pready && !pwrite) ? prdata : '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter
//   Directed bench for apb_req_arbiter with default parameters. Expected
//   completions are queued when a request is driven and compared when the
//   DUT pulses rsp_valid.
module tb_apb_req_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NR   = 2;
    localparam int TO   = 16;
    localparam int ID_W = $clog2(NR);
    localparam int SW   = DW / 8;

    logic               pclk;
    logic               presetn;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*AW-1:0]   req_addr;
    logic [NR-1:0]      req_write;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR*SW-1:0]   req_strb;
    logic [NR*3-1:0]    req_prot;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_slverr;
    logic [AW-1:0]      paddr;
    logic [2:0]         pprot;
    logic               pnse;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [DW-1:0]      pwdata;
    logic [SW-1:0]      pstrb;
    logic               pready;
    logic [DW-1:0]      prdata;
    logic               pslverr;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [DW-1:0]   rdata;
        logic            slverr;
    } rsp_t;

    rsp_t sb[$];
    rsp_t mon_exp;
    int   checks   = 0;
    int   failures = 0;

    apb_req_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
        .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr),
        .paddr(paddr), .pprot(pprot), .pnse(pnse), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                           input logic [2:0] prot);
        req_write[i]           = wr;
        req_addr[i*AW +: AW]   = addr;
        req_wdata[i*DW +: DW]  = wdata;
        req_strb[i*SW +: SW]   = strb;
        req_prot[i*3 +: 3]     = prot;
    endtask

    // Completion scoreboard plus per-cycle handshake rules.
    always @(negedge pclk) begin
        if (presetn) begin
            check("req_ready_onehot0", 64'($onehot0(req_ready)), 64'(1));
            check("req_ready_idle_only", 64'(psel && (req_ready != '0)), 64'(0));
            if (rsp_valid) begin
                check("rsp_expected", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(mon_exp.id));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(mon_exp.rdata));
                    check("rsp_slverr", 64'(rsp_slverr), 64'(mon_exp.slverr));
                end
            end
        end
    end

    // A completed ACCESS must release the bus right after the edge.
    always @(posedge pclk) begin
        if (presetn && psel && penable && pready) begin
            #1;
            if (presetn) begin
                check("release_psel", 64'(psel), 64'(0));
                check("release_penable", 64'(penable), 64'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_access;
        logic [ID_W-1:0] exp_id;

        presetn   = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;

        // Reset state, with requests pending to prove req_ready is held low.
        #1 presetn = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rst_psel", 64'(psel), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_rsp_slverr", 64'(rsp_slverr), 64'(0));
        check("rst_paddr", 64'(paddr), 64'(0));
        check("pnse_zero", 64'(pnse), 64'(0));
        repeat (3) step();

        // Single write on req0, zero wait states, pready high throughout.
        presetn   = 1'b1;
        req_valid = 2'b01;
        set_req(0, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 3'b000);
        pready    = 1'b1;
        #1;
        check("wr_grant_T", 64'(req_ready), 64'(2'b01));
        sb.push_back('{id: 1'b0, rdata: '0, slverr: 1'b0});
        step();
        req_valid = '0;
        #1;
        check("wr_setup_psel", 64'(psel), 64'(1));
        check("wr_setup_penable", 64'(penable), 64'(0));
        check("wr_setup_paddr", 64'(paddr), 64'(32'h10));
        check("wr_setup_pwrite", 64'(pwrite), 64'(1));
        check("wr_setup_pwdata", 64'(pwdata), 64'(32'hA5A5_A5A5));
        check("wr_setup_pstrb", 64'(pstrb), 64'(4'hF));
        step();
        check("wr_access_penable", 64'(penable), 64'(1));
        check("wr_access_paddr", 64'(paddr), 64'(32'h10));
        step();
        check("wr_done_rsp_valid", 64'(rsp_valid), 64'(1));
        check("wr_done_paddr", 64'(paddr), 64'(0));
        check("wr_done_pwrite", 64'(pwrite), 64'(0));

        // Read on req1 with three wait states; fields stable in ACCESS.
        step();
        req_valid = 2'b10;
        set_req(1, 1'b0, 32'h200, 32'h0, 4'hF, 3'b010);
        pready = 1'b0;
        prdata = 32'hFFFF_FFFF;
        #1;
        check("rd_grant", 64'(req_ready), 64'(2'b10));
        sb.push_back('{id: 1'b1, rdata: 32'h1234, slverr: 1'b0});
        step();
        req_valid = '0;
        #1;
        check("rd_setup_psel", 64'(psel), 64'(1));
        check("rd_setup_pwrite", 64'(pwrite), 64'(0));
        check("rd_setup_pstrb", 64'(pstrb), 64'(0));
        for (int c = 0; c < 4; c++) begin
            step();
            pready = (c == 3);
            prdata = (c == 3) ? 32'h1234 : 32'hFFFF_FFFF;
            check("rd_access_psel", 64'(psel), 64'(1));
            check("rd_access_penable", 64'(penable), 64'(1));
            check("rd_access_paddr", 64'(paddr), 64'(32'h200));
            check("rd_access_pprot", 64'(pprot), 64'(3'b010));
            check("rd_access_pwrite", 64'(pwrite), 64'(0));
            check("rd_access_pstrb", 64'(pstrb), 64'(0));
        end
        step();
        pready = 1'b0;
        check("rd_done_psel", 64'(psel), 64'(0));
        check("rd_done_rsp_valid", 64'(rsp_valid), 64'(1));

        // Both requesters held valid: grants must alternate 0,1,0,1.
        req_valid = 2'b11;
        set_req(0, 1'b1, 32'h100, 32'h1111_1111, 4'h3, 3'b001);
        set_req(1, 1'b1, 32'h104, 32'h2222_2222, 4'hC, 3'b100);
        pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id  = (k % 2 == 1) ? 1'b1 : 1'b0;
            pslverr = (k == 2);
            #1;
            check("rr_grant", 64'(req_ready), exp_id ? 64'(2'b10) : 64'(2'b01));
            sb.push_back('{id: exp_id, rdata: '0, slverr: (k == 2)});
            step();
            check("rr_setup_paddr", 64'(paddr), exp_id ? 64'(32'h104) : 64'(32'h100));
            check("rr_setup_pwdata", 64'(pwdata), exp_id ? 64'(32'h2222_2222) : 64'(32'h1111_1111));
            step();
            step();
        end
        req_valid = '0;
        pslverr   = 1'b0;
        #1;
        check("rr_done_rsp_valid", 64'(rsp_valid), 64'(1));

        // Timeout: pready never rises; exactly TO ACCESS cycles, then error.
        step();
        req_valid = 2'b01;
        set_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000);
        pready = 1'b0;
        prdata = 32'hDEAD_BEEF;
        #1;
        check("to_grant", 64'(req_ready), 64'(2'b01));
        sb.push_back('{id: 1'b0, rdata: '0, slverr: 1'b1});
        step();
        req_valid = '0;
        n_access  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (psel && penable) n_access++;
            else break;
        end
        check("to_access_cycles", 64'(n_access), 64'(TO));
        check("to_rsp_valid", 64'(rsp_valid), 64'(1));
        check("to_psel", 64'(psel), 64'(0));

        // Reset during ACCESS: bus drops at once, no completion, and the
        // round-robin pointer restarts at requester 0.
        step();
        req_valid = 2'b01;
        set_req(0, 1'b1, 32'h40, 32'h4444_4444, 4'hF, 3'b000);
        #1;
        check("rst_mid_grant", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = '0;
        step();
        check("rst_mid_in_access", 64'(penable), 64'(1));
        #2;
        presetn   = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rst_mid_psel", 64'(psel), 64'(0));
        check("rst_mid_penable", 64'(penable), 64'(0));
        check("rst_mid_paddr", 64'(paddr), 64'(0));
        check("rst_mid_req_ready", 64'(req_ready), 64'(0));
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (2) step();
        presetn = 1'b1;
        set_req(0, 1'b1, 32'h50, 32'h5555_5555, 4'hF, 3'b000);
        set_req(1, 1'b1, 32'h60, 32'h6666_6666, 4'hF, 3'b000);
        pready = 1'b1;
        #1;
        check("post_rst_grant", 64'(req_ready), 64'(2'b01));
        sb.push_back('{id: 1'b0, rdata: '0, slverr: 1'b0});
        step();
        req_valid = '0;
        check("post_rst_paddr", 64'(paddr), 64'(32'h50));
        step();
        step();
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'(1));

        repeat (3) step();
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
